// File: rtl/lsu_dmem_adapter.sv
// RV32 load/store adapter in front of a word-wide data memory: lane shifting, masks, load extension, faults.
// Define LSU_MISALIGNED_SPLIT_EN to split word-crossing misaligned accesses into two memory cycles.
module lsu_dmem_adapter #(
  parameter int MEM_WORDS = 2048
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_store,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_fault,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_write_data,
  output logic [31:0] o_mem_write_mask,
  output logic        o_mem_write_enable,
  input  logic [31:0] i_mem_read_data
);

`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif
  localparam logic [31:0] BYTE_LIMIT = 32'(MEM_WORDS * 4);

  typedef enum logic [1:0] {IDLE, SECOND, RESP} state_t;

  typedef struct packed {
    logic        store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  function automatic logic [2:0] f3_size(input logic [1:0] w);
    case (w)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] size_mask(input logic [2:0] sz);
    case (sz)
      3'd1:    return 32'h0000_00FF;
      3'd2:    return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] f, input logic [2:0] f3);
    case (f3)
      3'b000:  return {{24{f[7]}}, f[7:0]};
      3'b001:  return {{16{f[15]}}, f[15:0]};
      3'b100:  return {24'h0, f[7:0]};
      3'b101:  return {16'h0, f[15:0]};
      default: return f;
    endcase
  endfunction

  state_t      state, state_nxt;
  req_t        hold;
  logic [31:0] lo_word;

  logic [2:0]  req_size;
  logic        req_illegal, req_range, req_misal, req_cross, req_fault, req_split;
  logic [31:0] req_last;
  logic [4:0]  req_sh;
  logic        accept;

  always_comb begin
    req_size = f3_size(i_req_funct3[1:0]);
    case (i_req_funct3)
      3'b000, 3'b001, 3'b010: req_illegal = 1'b0;
      3'b100, 3'b101:         req_illegal = i_req_store;
      default:                req_illegal = 1'b1;
    endcase
    // Byte-granular bound on both ends is the same as checking first and last word index.
    req_last  = i_req_addr + 32'(req_size) - 32'd1;
    req_range = (i_req_addr >= BYTE_LIMIT) || (req_last >= BYTE_LIMIT);
    req_misal = (req_size == 3'd2 && i_req_addr[0]) ||
                (req_size == 3'd4 && i_req_addr[1:0] != 2'b00);
    // A halfword at offset 1 is misaligned but fits one word, so it needs no second cycle.
    req_cross = ({1'b0, i_req_addr[1:0]} + req_size) > 3'd4;
    req_fault = req_illegal || req_range || (req_misal && !SPLIT_EN);
    req_split = SPLIT_EN && req_cross && !req_fault;
    req_sh    = {i_req_addr[1:0], 3'b000};
  end

  logic [2:0]  h_size;
  logic [4:0]  h_sh;
  logic [5:0]  h_rsh;
  logic [31:0] h_merged;

  assign h_size   = f3_size(hold.funct3[1:0]);
  assign h_sh     = {hold.addr[1:0], 3'b000};
  assign h_rsh    = 6'd32 - {1'b0, h_sh};
  assign h_merged = (lo_word >> h_sh) | (i_mem_read_data << h_rsh);

  assign o_req_ready = (state == IDLE) || (state == RESP && i_rsp_ready);
  assign accept      = i_req_valid && o_req_ready;
  assign o_rsp_valid = (state == RESP);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SECOND: state_nxt = RESP;
      default: begin
        if (accept)           state_nxt = req_split ? SECOND : RESP;
        else if (i_rsp_ready) state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    o_mem_addr         = '0;
    o_mem_write_data   = '0;
    o_mem_write_mask   = '0;
    o_mem_write_enable = 1'b0;
    case (state)
      SECOND: begin
        // Remaining lanes are the bits shifted out of the top of the first word.
        o_mem_addr         = {2'b00, hold.addr[31:2]} + 32'd1;
        o_mem_write_mask   = size_mask(h_size) >> h_rsh;
        o_mem_write_data   = hold.wdata >> h_rsh;
        o_mem_write_enable = hold.store;
      end
      default: begin
        if (accept && !req_fault) begin
          o_mem_addr         = {2'b00, i_req_addr[31:2]};
          o_mem_write_mask   = size_mask(req_size) << req_sh;
          o_mem_write_data   = i_req_wdata << req_sh;
          o_mem_write_enable = i_req_store;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold        <= '0;
      lo_word     <= '0;
      o_rsp_rdata <= '0;
      o_rsp_fault <= 1'b0;
    end else if (accept) begin
      hold        <= req_t'{i_req_store, i_req_funct3, i_req_addr, i_req_wdata};
      lo_word     <= i_mem_read_data;
      o_rsp_fault <= req_fault;
      o_rsp_rdata <= (req_fault || i_req_store || req_split) ? '0
                   : load_ext(i_mem_read_data >> req_sh, i_req_funct3);
    end else if (state == SECOND) begin
      o_rsp_fault <= 1'b0;
      o_rsp_rdata <= hold.store ? '0 : load_ext(h_merged, hold.funct3);
    end
  end

endmodule

// File: tb/tb_lsu_dmem_adapter.sv
// Bench for lsu_dmem_adapter: directed scenarios plus random traffic against a byte-array reference.
module tb_lsu_dmem_adapter;
  localparam int MW = 2048;
  localparam int AW = $clog2(MW);
`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_req_valid = 1'b0, i_req_store = 1'b0, i_rsp_ready = 1'b1;
  logic [2:0]  i_req_funct3 = '0;
  logic [31:0] i_req_addr = '0, i_req_wdata = '0, i_mem_read_data;
  logic        o_req_ready, o_rsp_valid, o_rsp_fault, o_mem_write_enable;
  logic [31:0] o_rsp_rdata, o_mem_addr, o_mem_write_data, o_mem_write_mask;

  lsu_dmem_adapter #(.MEM_WORDS(MW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_store(i_req_store), .i_req_funct3(i_req_funct3),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_fault(o_rsp_fault),
    .o_mem_addr(o_mem_addr), .o_mem_write_data(o_mem_write_data),
    .o_mem_write_mask(o_mem_write_mask), .o_mem_write_enable(o_mem_write_enable),
    .i_mem_read_data(i_mem_read_data)
  );

  always #5 i_clk = ~i_clk;

  // Downstream memory: combinational read, masked synchronous write.
  logic [31:0] mem [MW] = '{default: 32'h0};
  int we_cnt = 0;
  assign i_mem_read_data = (o_mem_addr < MW) ? mem[o_mem_addr[AW-1:0]] : 32'h0;
  always @(posedge i_clk) begin
    if (o_mem_write_enable) begin
      we_cnt <= we_cnt + 1;
      if (o_mem_addr < MW)
        mem[o_mem_addr[AW-1:0]] <= (mem[o_mem_addr[AW-1:0]] & ~o_mem_write_mask) |
                                   (o_mem_write_data & o_mem_write_mask);
    end
  end

  // Reference: flat byte array, little-endian.
  logic [7:0] rb [MW*4] = '{default: 8'h0};
  int errors = 0, checks = 0;
  logic [31:0] snap_addr, snap_mask, snap_data;
  logic        snap_we;

  task automatic ref_op(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic flt, output int lat, output int wes);
    int sz;
    bit legal;
    longint unsigned la;
    sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    la = a;
    rd = 0; flt = 0; lat = 1; wes = 0;
    if (!legal || la >= MW*4 || la + sz - 1 >= MW*4) flt = 1;
    else if ((a % sz) != 0 && !SPLIT) flt = 1;
    else begin
      if ((a % 4) + sz > 4) lat = 2;
      if (st) begin
        for (int i = 0; i < sz; i++) rb[la + i] = wd[8*i +: 8];
        wes = lat;
      end else begin
        for (int i = 0; i < sz; i++) rd = rd | (32'(rb[la + i]) << (8*i));
        if (!f3[2] && sz < 4 && rd[8*sz-1]) rd = rd | (32'hFFFF_FFFF << (8*sz));
      end
    end
  endtask

  // Drives one request with i_rsp_ready high; call and returns just after a posedge.
  task automatic xact(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic flt, output int lat, output int wes);
    int n, w0;
    w0 = we_cnt;
    i_req_valid = 1; i_req_store = st; i_req_funct3 = f3; i_req_addr = a; i_req_wdata = wd;
    i_rsp_ready = 1;
    #1;
    n = 0;
    while (!o_req_ready && n < 20) begin @(posedge i_clk); #2; n++; end
    snap_addr = o_mem_addr; snap_mask = o_mem_write_mask; snap_data = o_mem_write_data;
    snap_we = o_mem_write_enable;
    @(posedge i_clk); #1;
    i_req_valid = 0;
    lat = 1;
    while (!o_rsp_valid && lat < 20) begin @(posedge i_clk); #1; lat++; end
    rd = o_rsp_rdata; flt = o_rsp_fault;
    @(posedge i_clk); #1;
    wes = we_cnt - w0;
  endtask

  logic [31:0] rd, e_rd;
  logic        flt, e_flt;
  int          lat, wes, e_lat, e_wes;

  task automatic test_reset();
    #2 i_rst = 1;
    repeat (2) @(posedge i_clk);
    #1;
    checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_rsp_valid); end
    checks++; if (o_rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", o_rsp_rdata); end
    checks++; if (o_rsp_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", o_rsp_fault); end
    checks++; if (o_mem_write_enable !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", o_mem_write_enable); end
    i_rst = 0;
    #1;
    checks++; if (o_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", o_req_ready); end
    @(posedge i_clk); #1;
  endtask

  task automatic test_load_ext();
    ref_op(1, 3'b010, 32'h0, 32'hDEAD_BEEF, e_rd, e_flt, e_lat, e_wes);
    xact(1, 3'b010, 32'h0, 32'hDEAD_BEEF, rd, flt, lat, wes);
    checks++; if (wes !== 1) begin errors++; $display("FAIL sw_writes got %0d want 1", wes); end
    xact(0, 3'b000, 32'h3, 0, rd, flt, lat, wes);
    checks++; if (rd !== 32'hFFFF_FFDE) begin errors++; $display("FAIL lb got %h want ffffffde", rd); end
    xact(0, 3'b100, 32'h3, 0, rd, flt, lat, wes);
    checks++; if (rd !== 32'h0000_00DE) begin errors++; $display("FAIL lbu got %h want 000000de", rd); end
    xact(0, 3'b001, 32'h2, 0, rd, flt, lat, wes);
    checks++; if (rd !== 32'hFFFF_DEAD || lat !== 1) begin errors++; $display("FAIL lh got %h lat %0d want ffffdead lat 1", rd, lat); end
  endtask

  task automatic test_store_lanes();
    ref_op(1, 3'b000, 32'h5, 32'h0000_00AA, e_rd, e_flt, e_lat, e_wes);
    xact(1, 3'b000, 32'h5, 32'h0000_00AA, rd, flt, lat, wes);
    checks++; if (snap_addr !== 32'd1) begin errors++; $display("FAIL sb_addr got %h want 1", snap_addr); end
    checks++; if (snap_mask !== 32'h0000_FF00) begin errors++; $display("FAIL sb_mask got %h want 0000ff00", snap_mask); end
    checks++; if (snap_data !== 32'h0000_AA00) begin errors++; $display("FAIL sb_data got %h want 0000aa00", snap_data); end
    checks++; if (snap_we !== 1'b1 || wes !== 1) begin errors++; $display("FAIL sb_we got %b/%0d want 1/1", snap_we, wes); end
    checks++; if (lat !== 1 || flt !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL sb_rsp got lat %0d flt %b rd %h want 1 0 0", lat, flt, rd); end
    checks++; if (mem[1] !== 32'h0000_AA00) begin errors++; $display("FAIL sb_mem got %h want 0000aa00", mem[1]); end
  endtask

  task automatic test_misaligned();
    ref_op(1, 3'b010, 32'h0, 32'h4433_2211, e_rd, e_flt, e_lat, e_wes);
    xact(1, 3'b010, 32'h0, 32'h4433_2211, rd, flt, lat, wes);
    ref_op(1, 3'b010, 32'h4, 32'h8877_6655, e_rd, e_flt, e_lat, e_wes);
    xact(1, 3'b010, 32'h4, 32'h8877_6655, rd, flt, lat, wes);
    xact(0, 3'b010, 32'h2, 0, rd, flt, lat, wes);
    if (SPLIT) begin
      checks++; if (rd !== 32'h6655_4433 || flt !== 1'b0) begin errors++; $display("FAIL lw_split got %h flt %b want 66554433 0", rd, flt); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL lw_split_lat got %0d want 2", lat); end
    end else begin
      checks++; if (flt !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL lw_mis got flt %b rd %h want 1 0", flt, rd); end
      checks++; if (snap_we !== 1'b0 || snap_mask !== 32'h0 || wes !== 0) begin errors++; $display("FAIL lw_mis_access got we %b mask %h writes %0d want 0", snap_we, snap_mask, wes); end
    end
  endtask

  task automatic test_range();
    xact(0, 3'b010, 32'(MW*4), 0, rd, flt, lat, wes);
    checks++; if (flt !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL lw_oor got flt %b rd %h want 1 0", flt, rd); end
    checks++; if (snap_mask !== 32'h0 || snap_addr !== 32'h0) begin errors++; $display("FAIL lw_oor_access got addr %h mask %h want 0", snap_addr, snap_mask); end
    xact(1, 3'b010, 32'(MW*4 - 2), 32'h1234_5678, rd, flt, lat, wes);
    checks++; if (flt !== 1'b1 || wes !== 0) begin errors++; $display("FAIL sw_edge got flt %b writes %0d want 1 0", flt, wes); end
    xact(0, 3'b011, 32'h0, 0, rd, flt, lat, wes);
    checks++; if (flt !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL f3_011 got flt %b rd %h want 1 0", flt, rd); end
    xact(1, 3'b100, 32'h8, 32'hFF, rd, flt, lat, wes);
    checks++; if (flt !== 1'b1 || wes !== 0) begin errors++; $display("FAIL st_f3_100 got flt %b writes %0d want 1 0", flt, wes); end
  endtask

  task automatic test_backpressure();
    i_rsp_ready = 0;
    i_req_valid = 1; i_req_store = 0; i_req_funct3 = 3'b010; i_req_addr = 32'h0;
    @(posedge i_clk); #1;
    i_req_valid = 0;
    checks++; if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== 32'h4433_2211) begin errors++; $display("FAIL bp_first got v %b rd %h want 1 44332211", o_rsp_valid, o_rsp_rdata); end
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clk); #1;
      checks++;
      if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== 32'h4433_2211 || o_req_ready !== 1'b0 || o_mem_write_enable !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d got v %b rd %h rdy %b we %b want 1 44332211 0 0", i, o_rsp_valid, o_rsp_rdata, o_req_ready, o_mem_write_enable);
      end
    end
    i_req_valid = 1; i_req_addr = 32'h4; i_rsp_ready = 1;
    #1;
    checks++; if (o_req_ready !== 1'b1) begin errors++; $display("FAIL bp_accept got %b want 1", o_req_ready); end
    @(posedge i_clk); #1;
    i_req_valid = 0;
    checks++; if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== 32'h8877_6655) begin errors++; $display("FAIL bp_next got v %b rd %h want 1 88776655", o_rsp_valid, o_rsp_rdata); end
    @(posedge i_clk); #1;
    checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_idle got %b want 0", o_rsp_valid); end
  endtask

  task automatic test_reset_pending();
    i_rsp_ready = 0;
    i_req_valid = 1; i_req_store = 0; i_req_funct3 = 3'b010; i_req_addr = 32'h0;
    @(posedge i_clk); #1;
    i_req_valid = 0;
    i_rst = 1;
    #1;
    checks++; if (o_rsp_valid !== 1'b0 || o_rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_drop got v %b rd %h want 0 0", o_rsp_valid, o_rsp_rdata); end
    @(posedge i_clk); #1;
    i_rst = 0; i_rsp_ready = 1;
    @(posedge i_clk); #1;
  endtask

  task automatic test_split_reset();
    i_req_valid = 1; i_req_store = 1; i_req_funct3 = 3'b010; i_req_addr = 32'h3; i_req_wdata = 32'hCCBB_AA99;
    i_rsp_ready = 1;
    @(posedge i_clk); #1;
    i_req_valid = 0;
    i_rst = 1;
    #1;
    checks++; if (o_rsp_valid !== 1'b0 || o_mem_write_enable !== 1'b0) begin errors++; $display("FAIL split_rst got v %b we %b want 0 0", o_rsp_valid, o_mem_write_enable); end
    @(posedge i_clk); #1;
    checks++; if (mem[1] !== 32'h8877_6655) begin errors++; $display("FAIL split_rst_w1 got %h want 88776655", mem[1]); end
    checks++; if (mem[0] !== 32'h9933_2211) begin errors++; $display("FAIL split_rst_w0 got %h want 99332211", mem[0]); end
    i_rst = 0;
    rb[3] = 8'h99;
    #1;
    checks++; if (o_req_ready !== 1'b1) begin errors++; $display("FAIL split_rst_idle got %b want 1", o_req_ready); end
    @(posedge i_clk); #1;
  endtask

  task automatic test_random();
    logic st;
    logic [2:0] f3;
    logic [31:0] a, wd;
    for (int n = 0; n < 200; n++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      wd = $urandom;
      case ($urandom_range(0, 3))
        0, 1:    a = 32'($urandom_range(0, 31));
        2:       a = 32'(MW*4 - $urandom_range(1, 8));
        default: a = ($urandom_range(0, 1) == 1) ? 32'(MW*4 + $urandom_range(0, 7)) : $urandom;
      endcase
      ref_op(st, f3, a, wd, e_rd, e_flt, e_lat, e_wes);
      xact(st, f3, a, wd, rd, flt, lat, wes);
      checks++;
      if (rd !== e_rd || flt !== e_flt || lat !== e_lat || wes !== e_wes) begin
        errors++;
        $display("FAIL rand%0d st %b f3 %0d a %h: got rd %h flt %b lat %0d wr %0d want %h %b %0d %0d",
                 n, st, f3, a, rd, flt, lat, wes, e_rd, e_flt, e_lat, e_wes);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_ext();
    test_store_lanes();
    test_misaligned();
    test_range();
    test_backpressure();
    test_reset_pending();
    if (SPLIT) test_split_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
